// File: rtl/ysyx_lsu.sv
// Multi-cycle load/store unit: takes one operation from execute and issues a sized,
// lane-aligned valid/ready bus request, then returns extended load data or a store ack.
module ysyx_lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q;
  logic              in_ready_q, out_valid_q, req_valid_q, stale_q;
  logic [CntW-1:0]   cnt_q;
  logic              store_q, uns_q;
  logic [1:0]        size_q;
  logic [OffW-1:0]   off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, data_q;
  logic [NB-1:0]     wmask_q;
  logic [4:0]        rd_q;
  logic              wen_q, err_q;

  // Operation decode on the execute-side inputs
  logic [ADDR_W-1:0] eff;
  logic [OffW-1:0]   off_d;
  logic [1:0]        size_d;
  logic              uns_d, illegal, misalign;
  logic [2:0]        align_mask;
  logic [NB-1:0]     size_mask;

  assign eff   = in_base + in_imm;
  assign off_d = eff[OffW-1:0];

  always_comb begin
    size_d  = 2'd0;
    uns_d   = 1'b0;
    illegal = 1'b0;
    case (in_funct3)
      3'b000: size_d = 2'd0;
      3'b001: size_d = 2'd1;
      3'b010: size_d = 2'd2;
      3'b100: begin size_d = 2'd0; uns_d = 1'b1; illegal = in_store; end
      3'b101: begin size_d = 2'd1; uns_d = 1'b1; illegal = in_store; end
      3'b011: begin size_d = 2'd3; illegal = (XLEN != 64); end
      3'b110: begin size_d = 2'd2; uns_d = 1'b1; illegal = (XLEN != 64) || in_store; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    align_mask = 3'b000;
    size_mask  = NB'(1);
    case (size_d)
      2'd0: begin align_mask = 3'b000; size_mask = NB'(1);  end
      2'd1: begin align_mask = 3'b001; size_mask = NB'(3);  end
      2'd2: begin align_mask = 3'b011; size_mask = NB'(15); end
      default: begin align_mask = 3'b111; size_mask = '1; end
    endcase
  end

  assign misalign = (eff[2:0] & align_mask) != 3'b000;

  // Load lane extraction and extension from the captured size/offset
  logic [XLEN-1:0] rd_shift, ld_mask, ld_val;
  logic            ld_sign;

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_mask = '1;
    ld_sign = 1'b0;
    case (size_q)
      2'd0: begin ld_mask = XLEN'(8'hFF);         ld_sign = rd_shift[7];  end
      2'd1: begin ld_mask = XLEN'(16'hFFFF);      ld_sign = rd_shift[15]; end
      2'd2: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = rd_shift[31]; end
      default: begin ld_mask = '1; ld_sign = 1'b0; end
    endcase
    ld_val = (rd_shift & ld_mask) | ((!uns_q && ld_sign) ? ~ld_mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      req_valid_q <= 1'b0;
      stale_q     <= 1'b0;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rd_q        <= 5'd0;
      data_q      <= '0;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // A response arriving while stale belongs to a timed-out request: drop it
      if (mem_resp_valid && stale_q) stale_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            store_q    <= in_store;
            uns_q      <= uns_d;
            size_q     <= size_d;
            off_q      <= off_d;
            addr_q     <= {eff[ADDR_W-1:OffW], {OffW{1'b0}}};
            wdata_q    <= in_wdata << {off_d, 3'b000};
            wmask_q    <= in_store ? (size_mask << off_d) : '0;
            rd_q       <= in_rd;
            if (illegal || misalign) begin
              state_q     <= StResp;
              out_valid_q <= 1'b1;
              data_q      <= '0;
              wen_q       <= 1'b0;
              err_q       <= 1'b1;
            end else begin
              state_q     <= StReq;
              req_valid_q <= !(stale_q && !mem_resp_valid);
            end
          end
        end
        StReq: begin
          if (req_valid_q && mem_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
          end else if (stale_q && mem_resp_valid) begin
            req_valid_q <= 1'b1;
          end
        end
        StWait: begin
          if (mem_resp_valid && !stale_q) begin
            state_q     <= StResp;
            out_valid_q <= 1'b1;
            err_q       <= mem_resp_err;
            wen_q       <= !store_q && !mem_resp_err;
            data_q      <= (store_q || mem_resp_err) ? '0 : ld_val;
          end else if (TIMEOUT_CYC != 0 && cnt_q == CntLast) begin
            state_q     <= StResp;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            wen_q       <= 1'b0;
            data_q      <= '0;
            stale_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = data_q;
  assign out_rd        = rd_q;
  assign out_wen       = wen_q;
  assign out_err       = err_q;
  assign mem_req_valid = req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_we        = store_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu (XLEN=32, short timeout): the bench plays execute,
// writeback and a zero-wait bus, and compares against hand-computed values.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_base, in_imm, in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_err;

  ysyx_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store), .in_funct3(in_funct3),
    .in_base(in_base), .in_imm(in_imm), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Results of the last operation
  int          o_lat, o_req_cyc;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [3:0]  o_wmask;
  logic [4:0]  o_rd;
  logic        o_we, o_wen, o_err;

  // Issue one op at cycle 0 and play a zero-wait bus until out_valid; returns at that
  // cycle's negedge so the caller still controls out_ready for the handshake edge.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic rerr, input bit mute,
                       input int late_at);
    bit pend = 0;
    bit seen = 0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1; in_store = st; in_funct3 = f3; in_base = base; in_imm = imm;
    in_wdata = wdata; in_rd = rd;
    o_lat = -1; o_req_cyc = -1;
    for (int c = 1; c <= 30 && !seen; c++) begin
      @(negedge clk);
      in_valid = 0;
      mem_resp_valid = 0; mem_resp_err = 0; mem_rdata = '0;
      if (c == late_at) begin
        mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
      end else if (pend) begin
        mem_resp_valid = 1; mem_rdata = rdata; mem_resp_err = rerr;
      end
      pend = 0;
      if (mem_req_valid && o_req_cyc < 0) begin
        o_req_cyc = c; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
        o_wmask = mem_wmask;
      end
      if (mem_req_valid && !mute) pend = 1;
      if (out_valid) begin
        seen = 1; o_lat = c; o_data = out_data; o_rd = out_rd; o_wen = out_wen;
        o_err = out_err;
      end
    end
    mem_resp_valid = 0; mem_resp_err = 0;
    check("out_valid_seen", seen, 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_store = 0; in_funct3 = 0; in_base = 0; in_imm = 0;
    in_wdata = 0; in_rd = 0; out_ready = 1; mem_req_ready = 1; mem_resp_valid = 0;
    mem_rdata = 0; mem_resp_err = 0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_wen", out_wen, 0);
    check("rst_wmask", mem_wmask, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // LW 0x8000_0004, negative imm wraps through the adder
    do_op(0, 3'b010, 32'h8000_0008, 32'hFFFF_FFFC, 0, 5'd7, 32'hDEAD_BEEF, 0, 0, -1);
    check("lw_lat", o_lat, 3);
    check("lw_req_cyc", o_req_cyc, 1);
    check("lw_addr", o_addr, 32'h8000_0004);
    check("lw_we", o_we, 0);
    check("lw_wmask", o_wmask, 0);
    check("lw_data", o_data, 32'hDEAD_BEEF);
    check("lw_rd", o_rd, 7);
    check("lw_wen", o_wen, 1);
    check("lw_err", o_err, 0);

    // LB / LBU at 0x103, top byte 0x80
    do_op(0, 3'b000, 32'h100, 32'h3, 0, 5'd1, 32'h8000_0000, 0, 0, -1);
    check("lb_addr", o_addr, 32'h100);
    check("lb_data", o_data, 32'hFFFF_FF80);
    do_op(0, 3'b100, 32'h100, 32'h3, 0, 5'd1, 32'h8000_0000, 0, 0, -1);
    check("lbu_data", o_data, 32'h0000_0080);

    // LH at 0x102 sign extends upper half; LHU zero extends
    do_op(0, 3'b001, 32'h100, 32'h2, 0, 5'd2, 32'h9ABC_1234, 0, 0, -1);
    check("lh_data", o_data, 32'hFFFF_9ABC);
    do_op(0, 3'b101, 32'h100, 32'h2, 0, 5'd2, 32'h9ABC_1234, 0, 0, -1);
    check("lhu_data", o_data, 32'h0000_9ABC);

    // SH at 0x102
    do_op(1, 3'b001, 32'h100, 32'h2, 32'h1234_ABCD, 5'd3, 32'hFFFF_FFFF, 0, 0, -1);
    check("sh_lat", o_lat, 3);
    check("sh_addr", o_addr, 32'h100);
    check("sh_we", o_we, 1);
    check("sh_wmask", o_wmask, 4'b1100);
    check("sh_wdata", o_wdata, 32'hABCD_0000);
    check("sh_wen", o_wen, 0);
    check("sh_data", o_data, 0);
    check("sh_err", o_err, 0);

    // SB at 0x101
    do_op(1, 3'b000, 32'h101, 32'h0, 32'h0000_00A5, 5'd0, 0, 0, 0, -1);
    check("sb_wmask", o_wmask, 4'b0010);
    check("sb_wdata", o_wdata, 32'h0000_A500);

    // Misaligned LW, XLEN=32 LD, and SBU: error after one cycle, no bus request
    do_op(0, 3'b010, 32'h100, 32'h1, 0, 5'd4, 0, 0, 0, -1);
    check("mis_lat", o_lat, 1);
    check("mis_no_req", o_req_cyc, -1);
    check("mis_err", o_err, 1);
    check("mis_data", o_data, 0);
    check("mis_wen", o_wen, 0);
    do_op(0, 3'b011, 32'h100, 32'h0, 0, 5'd4, 0, 0, 0, -1);
    check("ld32_lat", o_lat, 1);
    check("ld32_no_req", o_req_cyc, -1);
    check("ld32_err", o_err, 1);
    do_op(1, 3'b100, 32'h100, 32'h0, 32'h55, 5'd0, 0, 0, 0, -1);
    check("sbu_no_req", o_req_cyc, -1);
    check("sbu_err", o_err, 1);

    // Bus error on a load
    do_op(0, 3'b010, 32'h200, 32'h0, 0, 5'd5, 32'h1111_1111, 1, 0, -1);
    check("berr_lat", o_lat, 3);
    check("berr_err", o_err, 1);
    check("berr_data", o_data, 0);
    check("berr_wen", o_wen, 0);

    // Writeback backpressure for 5 cycles with a competing op on the input
    do_op(0, 3'b010, 32'h200, 32'h0, 0, 5'd6, 32'h1122_3344, 0, 0, -1);
    check("bp_data0", o_data, 32'h1122_3344);
    out_ready = 0;
    in_valid = 1; in_store = 0; in_funct3 = 3'b010; in_base = 32'h204; in_imm = 0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 32'h1122_3344);
      check("bp_in_ready", in_ready, 0);
      check("bp_no_req", mem_req_valid, 0);
    end
    out_ready = 1; in_valid = 0;

    // Timeout with no response after 4 WAIT cycles
    do_op(0, 3'b010, 32'h300, 32'h0, 0, 5'd8, 0, 0, 1, -1);
    check("tmo_req_cyc", o_req_cyc, 1);
    check("tmo_lat", o_lat, 6);
    check("tmo_err", o_err, 1);
    check("tmo_data", o_data, 0);
    check("tmo_wen", o_wen, 0);

    // Next load stalls until the late response is dropped, then gets its own data
    do_op(0, 3'b010, 32'h304, 32'h0, 0, 5'd9, 32'hCAFE_F00D, 0, 0, 3);
    check("stale_req_cyc", o_req_cyc, 4);
    check("stale_lat", o_lat, 6);
    check("stale_data", o_data, 32'hCAFE_F00D);
    check("stale_err", o_err, 0);

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    in_valid = 1; in_store = 0; in_funct3 = 3'b010; in_base = 32'h400; in_imm = 0;
    @(negedge clk);
    in_valid = 0;
    check("rw_req", mem_req_valid, 1);
    @(negedge clk);
    check("rw_wait_busy", in_ready, 0);
    #2 rst = 1;
    #1;
    check("rw_in_ready", in_ready, 1);
    check("rw_out_valid", out_valid, 0);
    check("rw_req_valid", mem_req_valid, 0);
    @(negedge clk);
    rst = 0;

    do_op(0, 3'b100, 32'h100, 32'h3, 0, 5'd10, 32'h8000_0000, 0, 0, -1);
    check("post_rst_lat", o_lat, 3);
    check("post_rst_data", o_data, 32'h0000_0080);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
